button_debounce: RTL and testbench

// Synchronises and debounces NUM_BTNS asynchronous push-button inputs. Each output
// is a clean, glitch-free level. It sits directly upstream of the per-button edge

---
 rtl/button_debounce.sv | 121 ++++++++++++
 tb/tb_button_debounce.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronises and debounces NUM_BTNS asynchronous push-button
//            inputs into clean, glitch-free levels for the per-button edge
//            detector feeding the mole-hit logic. Channels are independent.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_BTNS         number of button channels (>= 1)
//   DEBOUNCE_CYCLES  clk cycles a new level must hold before it is accepted
//                    (>= 2; 1000000 = 10 ms at 100 MHz)
// Ports
//   clk        in   1         system clock, all logic on posedge
//   n_reset    in   1         asynchronous, active-low reset
//   btn_raw    in   NUM_BTNS  raw button pins, asynchronous to clk, active-high
//   btn_level  out  NUM_BTNS  debounced level per channel, registered
//   btn_busy   out  NUM_BTNS  1 while a channel is qualifying a candidate change
// ============================================================================
module button_debounce #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_busy
);

  // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1, so clog2 bits suffice.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser per bit. Only the second stage is consumed.
  // --------------------------------------------------------------------------
  logic [NUM_BTNS-1:0] sync1;
  logic [NUM_BTNS-1:0] sync2;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel qualification FSM.
  // A candidate change must be seen on sync2 for DEBOUNCE_CYCLES consecutive
  // cycles; any reversion throws away all accumulated credit. Because the
  // counter is cleared on acceptance, the level can change at most once per
  // DEBOUNCE_CYCLES cycles.
  // --------------------------------------------------------------------------
  genvar ch;
  generate
    for (ch = 0; ch < NUM_BTNS; ch++) begin : g_chan
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic             level;
      logic             busy;

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          state <= ST_STABLE;
          cnt   <= '0;
          level <= 1'b0;
          busy  <= 1'b0;
        end else begin
          case (state)
            ST_STABLE: begin
              if (sync2[ch] != level) begin
                // The first differing sample already counts as cycle 1.
                state <= ST_QUALIFY;
                cnt   <= CNT_ONE;
                busy  <= 1'b1;
              end
            end

            ST_QUALIFY: begin
              if (sync2[ch] == level) begin
                // Bounced back: drop the candidate, no partial credit kept.
                state <= ST_STABLE;
                cnt   <= '0;
                busy  <= 1'b0;
              end else if (cnt == CNT_LAST) begin
                // Held for the full window: accept the new level.
                state <= ST_STABLE;
                cnt   <= '0;
                level <= sync2[ch];
                busy  <= 1'b0;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end

            default: begin
              state <= ST_STABLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          endcase
        end
      end

      assign btn_level[ch] = level;
      assign btn_busy[ch]  = busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench for button_debounce (4 channels, window 4).
//            Directed scenarios plus a long randomised run, all compared
//            against a behavioural model of the debounce rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  localparam int NB = 4;
  localparam int DC = 4;

  logic          clk      = 1'b0;
  logic          n_reset  = 1'b1;
  logic [NB-1:0] btn_raw  = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_busy;

  int checks = 0;
  int errors = 0;

  button_debounce #(
    .NUM_BTNS        (NB),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_busy  (btn_busy)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: the synchronised input is simply the raw input delayed
  // by two clock edges. A channel accepts a new level once the synchronised
  // input has disagreed with the current level for DC consecutive edges;
  // it is busy whenever a disagreement streak is in progress.
  // --------------------------------------------------------------------------
  logic [NB-1:0] m_d1;
  logic [NB-1:0] m_d2;
  logic [NB-1:0] m_level;
  logic [NB-1:0] m_busy;
  int            m_streak [NB];

  task automatic model_reset();
    m_d1    = '0;
    m_d2    = '0;
    m_level = '0;
    m_busy  = '0;
    for (int i = 0; i < NB; i++) m_streak[i] = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NB; i++) begin
      if (m_d2[i] != m_level[i]) begin
        m_streak[i] = m_streak[i] + 1;
        if (m_streak[i] == DC) begin
          m_level[i]  = ~m_level[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
      m_busy[i] = (m_streak[i] != 0);
    end
    m_d2 = m_d1;
    m_d1 = btn_raw;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock edge: advance the model, then compare both outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", 32'(btn_level), 32'(m_level));
    check("busy", 32'(btn_busy), 32'(m_busy));
  endtask

  // Asynchronous reset asserted away from the clock edge, released at negedge.
  task automatic apply_reset();
    n_reset = 1'b0;
    model_reset();
    #1;
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_busy", 32'(btn_busy), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    #2;
    apply_reset();

    // 1: clean press on channel 0
    btn_raw = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 3) check("press_busy", 32'(btn_busy[0]), 32'd1);
      if (e < 6)  check("press_early", 32'(btn_level[0]), 32'd0);
    end
    check("press_level", 32'(btn_level[0]), 32'd1);

    // 2: bounce on channel 1 (3 high, 1 low, then steady high)
    btn_raw = '0;
    apply_reset();
    btn_raw[1] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      check("bounce_hi", 32'(btn_level[1]), 32'd0);
    end
    btn_raw[1] = 1'b0;
    step();
    check("bounce_lo", 32'(btn_level[1]), 32'd0);
    btn_raw[1] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("bounce_rise", 32'(btn_level[1]), (e == 6) ? 32'd1 : 32'd0);
    end

    // 3: release on channel 2, preceded by a 2-cycle low glitch
    btn_raw = '0;
    apply_reset();
    btn_raw[2] = 1'b1;
    for (int e = 0; e < 8; e++) step();
    check("rel_start", 32'(btn_level[2]), 32'd1);
    btn_raw[2] = 1'b0;
    step();
    step();
    btn_raw[2] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      check("rel_glitch", 32'(btn_level[2]), 32'd1);
    end
    btn_raw[2] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("rel_fall", 32'(btn_level[2]), (e == 6) ? 32'd0 : 32'd1);
    end

    // 4: simultaneous changes on channels 1 and 3
    btn_raw = '0;
    apply_reset();
    btn_raw = 4'b1010;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("simul", 32'(btn_level), (e == 6) ? 32'hA : 32'h0);
    end

    // 5: reset in the middle of qualification
    btn_raw = '0;
    apply_reset();
    btn_raw[0] = 1'b1;
    for (int e = 0; e < 4; e++) step();
    check("midq_busy", 32'(btn_busy[0]), 32'd1);
    apply_reset();
    for (int e = 1; e <= 6; e++) begin
      step();
      check("midq_rise", 32'(btn_level[0]), (e == 6) ? 32'd1 : 32'd0);
    end

    // 6: chatter on channel 3
    btn_raw = '0;
    apply_reset();
    for (int e = 0; e < 50; e++) begin
      btn_raw[3] = ~btn_raw[3];
      step();
      check("chatter", 32'(btn_level[3]), 32'd0);
    end
    btn_raw[3] = 1'b0;

    // Randomised run: sparse independent toggles with occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(11) == 0) btn_raw[i] = ~btn_raw[i];
      end
      if ($urandom_range(799) == 0) apply_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
